// File: rtl/dn_pkg.sv
// Shared definitions for the pipelined Benes distribution network.
//   dn_mode_e    : per-switch route mode (pass, cross, broadcast upper/lower)
//   dn_levels    : number of switch stages for an N-lane network
//   dn_next_lane : lane reached at stage s+1 by output lane 'lane' of stage s
package dn_pkg;

  typedef enum logic [1:0] {
    DN_PASS     = 2'b00,
    DN_CROSS    = 2'b01,
    DN_BCAST_UP = 2'b10,
    DN_BCAST_LO = 2'b11
  } dn_mode_e;

  function automatic int dn_levels(input int n);
    return 32'sd2 * $clog2(n) - 32'sd1;
  endfunction

  // First half of the network unshuffles inside shrinking blocks; the second
  // half applies the mirror-image perfect shuffle, so all-pass is identity.
  function automatic int dn_next_lane(input int n, input int s, input int lane);
    int m;
    int nl;
    int bsz;
    int base;
    int b;
    m  = $clog2(n);
    nl = 32'sd2 * m - 32'sd1;
    if (s < m - 32'sd1) begin
      bsz = n >>> s;
    end else begin
      bsz = n >>> (nl - 32'sd2 - s);
    end
    b    = lane % bsz;
    base = lane - b;
    if (s < m - 32'sd1) begin
      return base + (b % 32'sd2) * (bsz / 32'sd2) + b / 32'sd2;
    end else if (b < bsz / 32'sd2) begin
      return base + 32'sd2 * b;
    end else begin
      return base + 32'sd2 * (b - bsz / 32'sd2) + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/dn_switch.sv
// Combinational 2x2 routing switch.
//   mode_i : route mode (pass / cross / broadcast upper / broadcast lower)
//   up_i   : upper input lane,   lo_i : lower input lane
//   up_o   : upper output lane,  lo_o : lower output lane
module dn_switch
  import dn_pkg::*;
#(
  parameter int DW = 8
) (
  input  dn_mode_e        mode_i,
  input  logic [DW-1:0]   up_i,
  input  logic [DW-1:0]   lo_i,
  output logic [DW-1:0]   up_o,
  output logic [DW-1:0]   lo_o
);

  // Select both outputs from the mode.
  always_comb begin
    up_o = up_i;
    lo_o = lo_i;
    case (mode_i)
      DN_PASS:     begin up_o = up_i; lo_o = lo_i; end
      DN_CROSS:    begin up_o = lo_i; lo_o = up_i; end
      DN_BCAST_UP: begin up_o = up_i; lo_o = up_i; end
      DN_BCAST_LO: begin up_o = lo_i; lo_o = lo_i; end
      default:     begin up_o = up_i; lo_o = lo_i; end
    endcase
  end

endmodule

// File: rtl/dn_benes_pipe.sv
// Pipelined N-lane Benes distribution network with valid/ready handshake and
// double-buffered route configuration tagged per beat.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   cfg_valid_i/cfg_ready_o: route write into the inactive (shadow) bank
//   cfg_route_i            : 2 bits per switch, switch (s,j) at [2*(s*N/2+j) +: 2]
//   in_valid_i/in_ready_o  : input beat handshake, in_data_i lane k at [k*DW +: DW]
//   out_valid_o/out_ready_i: output beat handshake, out_data_o routed lanes
module dn_benes_pipe
  import dn_pkg::*;
#(
  parameter int N          = 64,
  parameter int DW_DATA    = 8,
  parameter int PIPE_EVERY = 1,
  parameter int N_LEVELS   = dn_levels(N)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [N_LEVELS*N-1:0]   cfg_route_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [N*DW_DATA-1:0]    in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [N*DW_DATA-1:0]    out_data_o
);

  localparam int L  = (N_LEVELS + PIPE_EVERY - 32'sd1) / PIPE_EVERY;
  localparam int CW = N_LEVELS * N;

  logic          act_bank_q, act_bank_d;
  logic [CW-1:0] bank0_q, bank0_d;
  logic [CW-1:0] bank1_q, bank1_d;
  logic          adv_s;
  logic          cfg_we_s;
  logic [L-1:0]  stale_s;

  // The whole pipe moves as one unit; bubbles are kept, not collapsed.
  assign adv_s       = ~out_valid_o | out_ready_i;
  assign in_ready_o  = adv_s;
  // The shadow bank is writable only once no beat still routes through it.
  assign cfg_ready_o = ~|stale_s;
  assign cfg_we_s    = cfg_valid_i & cfg_ready_o;

  // Config write targets the inactive bank and flips the active bank.
  always_comb begin
    act_bank_d = act_bank_q;
    bank0_d    = bank0_q;
    bank1_d    = bank1_q;
    if (cfg_we_s) begin
      act_bank_d = ~act_bank_q;
      if (act_bank_q) begin
        bank0_d = cfg_route_i;
      end else begin
        bank1_d = cfg_route_i;
      end
    end else begin
      act_bank_d = act_bank_q;
    end
  end

  // Bank and active-bank registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_bank_q <= 1'b0;
      bank0_q    <= '0;
      bank1_q    <= '0;
    end else begin
      act_bank_q <= act_bank_d;
      bank0_q    <= bank0_d;
      bank1_q    <= bank1_d;
    end
  end

  // Switch levels: each level reads config from the bank tagged on its beat.
  for (genvar s = 0; s < N_LEVELS; s++) begin : g_lvl
    localparam int G = s / PIPE_EVERY;
    logic [N-1:0][DW_DATA-1:0] din_s;
    logic [N-1:0][DW_DATA-1:0] dout_s;
    logic [N-1:0][DW_DATA-1:0] wout_s;
    logic                      tag_s;

    if (s == 0) begin : g_src_in
      assign din_s = in_data_i;
      assign tag_s = act_bank_q;
    end else if ((s % PIPE_EVERY) == 0) begin : g_src_reg
      assign din_s = g_stg[G-1].dat_q;
      assign tag_s = g_stg[G-1].tag_q;
    end else begin : g_src_wire
      assign din_s = g_lvl[s-1].wout_s;
      assign tag_s = g_lvl[s-1].tag_s;
    end

    for (genvar j = 0; j < N / 2; j++) begin : g_sw
      localparam int IDX = 32'sd2 * (s * (N / 32'sd2) + j);
      logic [1:0] mode_s;
      assign mode_s = tag_s ? bank1_q[IDX +: 2] : bank0_q[IDX +: 2];
      dn_switch #(.DW(DW_DATA)) u_sw (
        .mode_i (dn_mode_e'(mode_s)),
        .up_i   (din_s[2*j]),
        .lo_i   (din_s[2*j+1]),
        .up_o   (dout_s[2*j]),
        .lo_o   (dout_s[2*j+1])
      );
    end

    if (s < N_LEVELS - 1) begin : g_wire
      for (genvar k = 0; k < N; k++) begin : g_lane
        assign wout_s[dn_next_lane(N, s, k)] = dout_s[k];
      end
    end else begin : g_last
      assign wout_s = dout_s;
    end
  end

  // Pipeline stages: register r captures the wired output of its last level.
  for (genvar r = 0; r < L; r++) begin : g_stg
    localparam int E = ((((r + 32'sd1) * PIPE_EVERY) < N_LEVELS) ?
                        ((r + 32'sd1) * PIPE_EVERY) : N_LEVELS) - 32'sd1;
    logic                   vld_q, vld_d;
    logic                   tag_q, tag_d;
    logic [N*DW_DATA-1:0]   dat_q, dat_d;
    logic                   vld_in_s;
    logic                   tag_in_s;

    if (r == 0) begin : g_head
      assign vld_in_s = in_valid_i;
      // A beat accepted alongside a config write keeps the old bank.
      assign tag_in_s = act_bank_q;
    end else begin : g_body
      assign vld_in_s = g_stg[r-1].vld_q;
      assign tag_in_s = g_stg[r-1].tag_q;
    end

    // Shift on advance, otherwise hold.
    always_comb begin
      vld_d = vld_q;
      tag_d = tag_q;
      dat_d = dat_q;
      if (adv_s) begin
        vld_d = vld_in_s;
        tag_d = tag_in_s;
        dat_d = g_lvl[E].wout_s;
      end else begin
        vld_d = vld_q;
      end
    end

    // Stage register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= 1'b0;
        tag_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        tag_q <= tag_d;
        dat_q <= dat_d;
      end
    end

    assign stale_s[r] = vld_q & (tag_q ^ act_bank_q);
  end

  assign out_valid_o = g_stg[L-1].vld_q;
  assign out_data_o  = g_stg[L-1].dat_q;

endmodule

// File: tb/tb_dn_benes_pipe.sv
// Scoreboard bench for dn_benes_pipe with N=8, DW_DATA=8, PIPE_EVERY=1 (L=5).
module tb_dn_benes_pipe;
  import dn_pkg::*;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int NL = 5;
  localparam int L  = 5;

  // Stages 0..2 all-cross flip lane bits 0,1,2 -> out[k] = in[7-k].
  localparam logic [NL*N-1:0] CFG_REV   = 40'h00_00_55_55_55;
  // Switch (0,0) broadcasts its upper input, all others pass.
  localparam logic [NL*N-1:0] CFG_BC    = 40'h00_00_00_00_02;
  localparam logic [NL*N-1:0] CFG_IDENT = 40'h00_00_00_00_00;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              cfg_valid_i;
  logic              cfg_ready_o;
  logic [NL*N-1:0]   cfg_route_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [N*DW-1:0]   in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [N*DW-1:0]   out_data_o;

  logic [N*DW-1:0]   exp_q[$];
  logic [N*DW-1:0]   cur_exp;
  int                checks = 0;
  int                errors = 0;
  int                n_out = 0;
  int                stall_cnt = 0;
  bit                chk_cfg1 = 1'b0;
  bit                in_t3 = 1'b0;

  dn_benes_pipe #(.N(N), .DW_DATA(DW), .PIPE_EVERY(1)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_route_i (cfg_route_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [N*DW-1:0] mk(input logic [7:0] b);
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = b + 8'(k);
    return r;
  endfunction

  function automatic logic [N*DW-1:0] rev(input logic [N*DW-1:0] d);
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = d[(N-1-k)*DW +: DW];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      check("in_ready_rule", 64'(in_ready_o), 64'(!out_valid_o || out_ready_i));
      if (chk_cfg1) check("cfg_ready_idle", 64'(cfg_ready_o), 64'd1);
      if (in_t3 && !in_ready_o) stall_cnt++;
      if (in_valid_i && in_ready_o) exp_q.push_back(cur_exp);
      if (out_valid_o && out_ready_i) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%h required=none", out_data_o);
        end else begin
          check("out_data", out_data_o, exp_q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [N*DW-1:0] d, input logic [N*DW-1:0] e);
    int n = 0;
    cur_exp    = e;
    in_data_i  = d;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    while (!in_ready_o && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=%0d required<50", n);
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic cfg_write(input logic [NL*N-1:0] r);
    int n = 0;
    cfg_route_i = r;
    cfg_valid_i = 1'b1;
    @(negedge clk_i);
    while (!cfg_ready_o && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL cfg_timeout actual=%0d required<50", n);
    end
    @(posedge clk_i);
    #1;
    cfg_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0;
    rst_ni      = 1'b0;
    cfg_valid_i = 1'b0;
    cfg_route_i = '0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b1;
    cur_exp     = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_out_data",  out_data_o, 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready_o), 64'd1);
    check("rst_in_ready",  64'(in_ready_o), 64'd1);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // 1: identity with default config, latency L.
    chk_cfg1 = 1'b1;
    send(mk(8'h10), 64'h1716151413121110);
    n = 1;
    @(negedge clk_i);
    while (!out_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("latency", 64'(n), 64'(L));
    wait_drain();
    chk_cfg1 = 1'b0;

    // 2: reverse routing.
    cfg_write(CFG_REV);
    send(mk(8'h10), 64'h1011121314151617);
    wait_drain();

    // 3: 8-beat stream with a 3-cycle downstream stall.
    n0 = n_out;
    stall_cnt = 0;
    in_t3 = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(mk(8'h20 + 8'(8 * i)), rev(mk(8'h20 + 8'(8 * i))));
        end
      end
      begin
        repeat (6) @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
      end
    join
    wait_drain();
    in_t3 = 1'b0;
    check("stream_count", 64'(n_out - n0), 64'd8);
    check("stall_cycles", 64'(stall_cnt), 64'd3);

    // 4: config committed with beat A; beat B uses the new bank; second write waits for A.
    cfg_write(CFG_IDENT);
    in_valid_i  = 1'b1;
    in_data_i   = mk(8'h30);
    cur_exp     = mk(8'h30);
    cfg_valid_i = 1'b1;
    cfg_route_i = CFG_REV;
    @(negedge clk_i);
    check("t4_accept_both", 64'({in_ready_o, cfg_ready_o}), 64'd3);
    @(posedge clk_i);
    #1;
    in_data_i   = mk(8'h40);
    cur_exp     = rev(mk(8'h40));
    cfg_route_i = CFG_BC;
    n = 0;
    @(negedge clk_i);
    while (!cfg_ready_o && n < 20) begin
      n++;
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      @(negedge clk_i);
    end
    @(posedge clk_i);
    #1;
    cfg_valid_i = 1'b0;
    in_valid_i  = 1'b0;
    check("t4_cfg_wait", 64'(n), 64'(L));
    wait_drain();

    // 5: switch (0,0) broadcast upper (bank written by the delayed write above).
    send(mk(8'h10), 64'h1716151413121010);
    wait_drain();

    // 6: reset with beats in flight, then identity after banks clear.
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(8'h50 + 8'(8 * i)), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    check("t6_inflight", 64'(out_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid_o), 64'd0);
    check("t6_rst_data",  out_data_o, 64'd0);
    exp_q.delete();
    @(posedge clk_i);
    #1;
    rst_ni      = 1'b1;
    out_ready_i = 1'b1;
    n0 = n_out;
    send(mk(8'h60), 64'h6766656463626160);
    wait_drain();
    check("t6_count", 64'(n_out - n0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
